ddr_dqsw_lane_trainer: RTL and testbench

Multi-lane DQS write-leveling training controller for the DDR4 PHY block. Drives the dynamic delay-line controls of one DQSW training IOD per lane and sweeps each lane's delay upward from tap 0. At each tap it samples the lane's eye-monitor EARLY/LATE flags and records the tap where the flags go from early to late. Lanes are trained one at a time, then an optional back-off is applied. Per-lane pass/fail and final tap are reported to the PHY sequencer.

---
 rtl/ddr_dqsw_pkg.sv | 32 +++
 rtl/ddr_dqsw_lane_mux.sv | 49 ++++
 rtl/ddr_dqsw_lane_trainer.sv | 238 +++++++++++++++++++++++
 tb/tb_ddr_dqsw_lane_trainer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_dqsw_pkg.sv
// Shared types for the DQS write-leveling lane trainer: FSM states, eye-sample
// classes and the EARLY/LATE flag classifier.
package ddr_dqsw_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_BACKOFF,
    S_NEXT_LANE,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    CLS_E,
    CLS_L,
    CLS_X
  } cls_e;

  // Exactly one flag set gives a definite class; both or neither is ambiguous.
  function automatic cls_e classify(input logic early, input logic late);
    case ({early, late})
      2'b10:   classify = CLS_E;
      2'b01:   classify = CLS_L;
      default: classify = CLS_X;
    endcase
  endfunction

endpackage

// File: rtl/ddr_dqsw_lane_mux.sv
// Lane steering: picks the active lane's eye/range flags and one-hot decodes the
// delay-line and flag-clear controls onto the per-lane vectors.
module ddr_dqsw_lane_mux #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned LANE_W    = 1
) (
  input  logic [LANE_W-1:0]    i_sel_lane,
  input  logic [NUM_LANES-1:0] i_early,
  input  logic [NUM_LANES-1:0] i_late,
  input  logic [NUM_LANES-1:0] i_oor,
  output logic                 o_early_c,
  output logic                 o_late_c,
  output logic                 o_oor_c,
  input  logic [LANE_W-1:0]    i_dec_lane,
  input  logic                 i_load,
  input  logic                 i_move,
  input  logic                 i_dir,
  input  logic                 i_clear,
  output logic [NUM_LANES-1:0] o_load_c,
  output logic [NUM_LANES-1:0] o_move_c,
  output logic [NUM_LANES-1:0] o_dir_c,
  output logic [NUM_LANES-1:0] o_clear_c
);

  always_comb begin
    o_early_c = 1'b0;
    o_late_c  = 1'b0;
    o_oor_c   = 1'b0;
    o_load_c  = '0;
    o_move_c  = '0;
    o_dir_c   = '0;
    o_clear_c = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_sel_lane == LANE_W'(l)) begin
        o_early_c = i_early[l];
        o_late_c  = i_late[l];
        o_oor_c   = i_oor[l];
      end
      if (i_dec_lane == LANE_W'(l)) begin
        o_load_c[l]  = i_load;
        o_move_c[l]  = i_move;
        // Direction is only meaningful alongside a move pulse.
        o_dir_c[l]   = i_dir & i_move;
        o_clear_c[l] = i_clear;
      end
    end
  end

endmodule

// File: rtl/ddr_dqsw_lane_trainer.sv
// DQS write-leveling trainer: sweeps each lane's delay from tap 0 until the eye
// monitor flips from EARLY to LATE, optionally backs off, and reports pass/tap.
module ddr_dqsw_lane_trainer
  import ddr_dqsw_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 2,
  parameter int unsigned TAP_WIDTH     = 8,
  parameter int unsigned MAX_TAPS      = 255,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned BACKOFF_TAPS  = 0
) (
  input  logic                           FAB_CLK,
  input  logic                           ARST_N,
  input  logic                           START,
  input  logic [NUM_LANES-1:0]           EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]           EYE_MONITOR_LATE,
  input  logic [NUM_LANES-1:0]           DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES-1:0]           DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]           DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]           DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]           EYE_MONITOR_CLEAR_FLAGS,
  output logic                           BUSY,
  output logic                           DONE,
  output logic [NUM_LANES-1:0]           LANE_PASS,
  output logic [NUM_LANES*TAP_WIDTH-1:0] LANE_TAP
);

  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned BO_CLAMP = (BACKOFF_TAPS > MAX_TAPS) ? MAX_TAPS : BACKOFF_TAPS;

  state_e                         r_state;
  state_e                         w_state_nxt;
  logic [LANE_W-1:0]              r_lane;
  logic [LANE_W-1:0]              w_lane_nxt;
  logic [TAP_WIDTH-1:0]           r_tap;
  logic [TAP_WIDTH-1:0]           w_tap_nxt;
  logic [TAP_WIDTH-1:0]           r_bo_cnt;
  logic [TAP_WIDTH-1:0]           w_bo_cnt_nxt;
  logic [SETTLE_W-1:0]            r_settle;
  logic [SETTLE_W-1:0]            w_settle_nxt;
  cls_e                           r_prev_cls;
  cls_e                           w_prev_cls_nxt;
  cls_e                           w_cur_cls;
  logic                           r_lane_ok;
  logic                           w_lane_ok_nxt;
  logic [NUM_LANES-1:0]           r_pass;
  logic [NUM_LANES-1:0]           w_pass_nxt;
  logic [NUM_LANES*TAP_WIDTH-1:0] r_taps;
  logic [NUM_LANES*TAP_WIDTH-1:0] w_taps_nxt;

  logic                           w_early;
  logic                           w_late;
  logic                           w_oor;
  logic                           w_load_p;
  logic                           w_move_p;
  logic                           w_dir_p;
  logic                           w_clear_p;
  logic [NUM_LANES-1:0]           w_load_vec;
  logic [NUM_LANES-1:0]           w_move_vec;
  logic [NUM_LANES-1:0]           w_dir_vec;
  logic [NUM_LANES-1:0]           w_clear_vec;
  logic [NUM_LANES-1:0]           r_load;
  logic [NUM_LANES-1:0]           r_move;
  logic [NUM_LANES-1:0]           r_dir;
  logic [NUM_LANES-1:0]           r_clear;
  logic                           r_busy;
  logic                           r_done;

  ddr_dqsw_lane_mux #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_lane_mux (
    .i_sel_lane (r_lane),
    .i_early    (EYE_MONITOR_EARLY),
    .i_late     (EYE_MONITOR_LATE),
    .i_oor      (DELAY_LINE_OUT_OF_RANGE),
    .o_early_c  (w_early),
    .o_late_c   (w_late),
    .o_oor_c    (w_oor),
    .i_dec_lane (w_lane_nxt),
    .i_load     (w_load_p),
    .i_move     (w_move_p),
    .i_dir      (w_dir_p),
    .i_clear    (w_clear_p),
    .o_load_c   (w_load_vec),
    .o_move_c   (w_move_vec),
    .o_dir_c    (w_dir_vec),
    .o_clear_c  (w_clear_vec)
  );

  // Control pulses are decoded from the next state so their registers line up
  // with the cycle the FSM spends in the matching state.
  assign w_load_p  = (w_state_nxt == S_LOAD);
  assign w_clear_p = (w_state_nxt == S_CLEAR);
  assign w_move_p  = (w_state_nxt == S_STEP) || (w_state_nxt == S_BACKOFF);
  assign w_dir_p   = (w_state_nxt == S_STEP);
  assign w_cur_cls = classify(w_early, w_late);

  always_comb begin
    w_state_nxt    = r_state;
    w_lane_nxt     = r_lane;
    w_tap_nxt      = r_tap;
    w_bo_cnt_nxt   = r_bo_cnt;
    w_settle_nxt   = r_settle;
    w_prev_cls_nxt = r_prev_cls;
    w_lane_ok_nxt  = r_lane_ok;
    w_pass_nxt     = r_pass;
    w_taps_nxt     = r_taps;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_pass_nxt  = '0;
          w_taps_nxt  = '0;
          w_lane_nxt  = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_tap_nxt      = '0;
        w_prev_cls_nxt = CLS_X;
        w_lane_ok_nxt  = 1'b0;
        w_state_nxt    = S_CLEAR;
      end
      S_CLEAR: begin
        w_settle_nxt = '0;
        w_state_nxt  = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_settle_nxt = r_settle + SETTLE_W'(1);
        end
      end
      S_SAMPLE: begin
        if (w_oor) begin
          w_lane_ok_nxt = 1'b0;
          w_state_nxt   = S_NEXT_LANE;
        end else if ((r_prev_cls == CLS_E) && (w_cur_cls == CLS_L)) begin
          w_lane_ok_nxt = 1'b1;
          if (BACKOFF_TAPS == 0) begin
            w_state_nxt = S_NEXT_LANE;
          end else begin
            // Back off min(BACKOFF_TAPS, edge tap); edge tap is always >= 1.
            w_state_nxt  = S_BACKOFF;
            w_bo_cnt_nxt = (r_tap > TAP_WIDTH'(BO_CLAMP)) ?
                           TAP_WIDTH'(BO_CLAMP) - TAP_WIDTH'(1) : r_tap - TAP_WIDTH'(1);
          end
        end else if (r_tap == TAP_WIDTH'(MAX_TAPS)) begin
          w_lane_ok_nxt = 1'b0;
          w_state_nxt   = S_NEXT_LANE;
        end else begin
          w_prev_cls_nxt = w_cur_cls;
          w_state_nxt    = S_STEP;
        end
      end
      S_STEP: begin
        w_tap_nxt   = r_tap + TAP_WIDTH'(1);
        w_state_nxt = S_CLEAR;
      end
      S_BACKOFF: begin
        w_tap_nxt = r_tap - TAP_WIDTH'(1);
        if (r_bo_cnt == '0) begin
          w_state_nxt = S_NEXT_LANE;
        end else begin
          w_bo_cnt_nxt = r_bo_cnt - TAP_WIDTH'(1);
        end
      end
      S_NEXT_LANE: begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (r_lane == LANE_W'(l)) begin
            w_pass_nxt[l] = r_lane_ok;
            w_taps_nxt[l*TAP_WIDTH +: TAP_WIDTH] = r_lane_ok ? r_tap : '0;
          end
        end
        if (r_lane == LANE_W'(NUM_LANES - 1)) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_lane_nxt  = r_lane + LANE_W'(1);
          w_state_nxt = S_LOAD;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_tap      <= '0;
      r_bo_cnt   <= '0;
      r_settle   <= '0;
      r_prev_cls <= CLS_X;
      r_lane_ok  <= 1'b0;
      r_pass     <= '0;
      r_taps     <= '0;
      r_load     <= '0;
      r_move     <= '0;
      r_dir      <= '0;
      r_clear    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane     <= w_lane_nxt;
      r_tap      <= w_tap_nxt;
      r_bo_cnt   <= w_bo_cnt_nxt;
      r_settle   <= w_settle_nxt;
      r_prev_cls <= w_prev_cls_nxt;
      r_lane_ok  <= w_lane_ok_nxt;
      r_pass     <= w_pass_nxt;
      r_taps     <= w_taps_nxt;
      r_load     <= w_load_vec;
      r_move     <= w_move_vec;
      r_dir      <= w_dir_vec;
      r_clear    <= w_clear_vec;
      r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FINISH);
      r_done     <= (w_state_nxt == S_FINISH);
    end
  end

  assign DELAY_LINE_LOAD         = r_load;
  assign DELAY_LINE_MOVE         = r_move;
  assign DELAY_LINE_DIRECTION    = r_dir;
  assign EYE_MONITOR_CLEAR_FLAGS = r_clear;
  assign BUSY                    = r_busy;
  assign DONE                    = r_done;
  assign LANE_PASS               = r_pass;
  assign LANE_TAP                = r_taps;

endmodule

// File: tb/tb_ddr_dqsw_lane_trainer.sv
// Bench for ddr_dqsw_lane_trainer: two instances (no back-off, back-off of 3)
// each driven by a delay-line/eye-monitor model and checked against a tap-walk model.
module tb_ddr_dqsw_lane_trainer;

  localparam int MAXT = 31;
  localparam int SET  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic [1:0]  early [2];
  logic [1:0]  late  [2];
  logic [1:0]  oor   [2];
  logic [1:0]  load  [2];
  logic [1:0]  move  [2];
  logic [1:0]  dir   [2];
  logic [1:0]  clr   [2];
  logic [1:0]  pass  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] ltap  [2];

  logic [1:0]  pat [2][2][32];
  int          oor_tap [2][2];
  int          mtap [2][2];
  int          up_cnt [2][2];
  int          dn_cnt [2][2];
  int          done_cnt [2];
  int          viol [2];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  ddr_dqsw_lane_trainer #(
    .NUM_LANES(2), .TAP_WIDTH(8), .MAX_TAPS(31), .SETTLE_CYCLES(4), .BACKOFF_TAPS(0)
  ) u_dut0 (
    .FAB_CLK(clk), .ARST_N(rst_n), .START(start[0]),
    .EYE_MONITOR_EARLY(early[0]), .EYE_MONITOR_LATE(late[0]),
    .DELAY_LINE_OUT_OF_RANGE(oor[0]),
    .DELAY_LINE_LOAD(load[0]), .DELAY_LINE_MOVE(move[0]),
    .DELAY_LINE_DIRECTION(dir[0]), .EYE_MONITOR_CLEAR_FLAGS(clr[0]),
    .BUSY(busy[0]), .DONE(done[0]), .LANE_PASS(pass[0]), .LANE_TAP(ltap[0])
  );

  ddr_dqsw_lane_trainer #(
    .NUM_LANES(2), .TAP_WIDTH(8), .MAX_TAPS(31), .SETTLE_CYCLES(4), .BACKOFF_TAPS(3)
  ) u_dut1 (
    .FAB_CLK(clk), .ARST_N(rst_n), .START(start[1]),
    .EYE_MONITOR_EARLY(early[1]), .EYE_MONITOR_LATE(late[1]),
    .DELAY_LINE_OUT_OF_RANGE(oor[1]),
    .DELAY_LINE_LOAD(load[1]), .DELAY_LINE_MOVE(move[1]),
    .DELAY_LINE_DIRECTION(dir[1]), .EYE_MONITOR_CLEAR_FLAGS(clr[1]),
    .BUSY(busy[1]), .DONE(done[1]), .LANE_PASS(pass[1]), .LANE_TAP(ltap[1])
  );

  // IOD model: tracks each lane's delay tap and presents that tap's flags.
  always @(posedge clk or negedge rst_n) begin : iod
    int nt;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        early[d] <= '0;
        late[d]  <= '0;
        oor[d]   <= '0;
        for (int l = 0; l < 2; l++) mtap[d][l] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
        if ($countones(load[d] | move[d] | clr[d]) > 1 || (dir[d] & ~move[d]) != 2'b00)
          viol[d] <= viol[d] + 1;
        for (int l = 0; l < 2; l++) begin
          nt = mtap[d][l];
          if (load[d][l]) nt = 0;
          else if (move[d][l]) nt = dir[d][l] ? nt + 1 : nt - 1;
          if (nt < 0) nt = 0;
          if (nt > MAXT) nt = MAXT;
          mtap[d][l]  <= nt;
          early[d][l] <= pat[d][l][nt][1];
          late[d][l]  <= pat[d][l][nt][0];
          oor[d][l]   <= (oor_tap[d][l] >= 0) && (nt >= oor_tap[d][l]);
          if (move[d][l] && dir[d][l])  up_cnt[d][l] <= up_cnt[d][l] + 1;
          if (move[d][l] && !dir[d][l]) dn_cnt[d][l] <= dn_cnt[d][l] + 1;
        end
      end
    end
  end

  function automatic int cls_of(input logic [1:0] f);
    if (f == 2'b10) return 0;
    if (f == 2'b01) return 1;
    return 2;
  endfunction

  // Walk the taps the way training is defined and derive result, pulses and duration.
  task automatic model(input int d, input int l, output int e_pass, output int e_tap,
                       output int e_up, output int e_dn, output int e_cyc);
    int prev, cur, stop_t, bo;
    bit fin;
    bo = (d == 0) ? 0 : 3;
    prev = 2; e_pass = 0; fin = 0; stop_t = 0;
    for (int t = 0; t <= MAXT; t++) begin
      stop_t = t;
      if (oor_tap[d][l] >= 0 && t >= oor_tap[d][l]) fin = 1;
      else begin
        cur = cls_of(pat[d][l][t]);
        if (prev == 0 && cur == 1) begin e_pass = 1; fin = 1; end
        else if (t == MAXT) fin = 1;
        else prev = cur;
      end
      if (fin) break;
    end
    e_up  = stop_t;
    e_dn  = e_pass ? ((bo < stop_t) ? bo : stop_t) : 0;
    e_tap = e_pass ? stop_t - e_dn : 0;
    e_cyc = 1 + stop_t * (SET + 3) + (SET + 2) + e_dn + 1;
  endtask

  task automatic set_edge(input int d, input int l, input int k);
    for (int t = 0; t < 32; t++) pat[d][l][t] = (t < k) ? 2'b10 : 2'b01;
    oor_tap[d][l] = -1;
  endtask

  task automatic run_train(input int d, input string name, input bit poke);
    int ep[2], et[2], eu[2], ed[2], ec, lc, u0[2], d0[2], dc0, v0, n, busy_bad;
    bit got;
    ec = 1;
    for (int l = 0; l < 2; l++) begin
      model(d, l, ep[l], et[l], eu[l], ed[l], lc);
      ec += lc;
      u0[l] = up_cnt[d][l];
      d0[l] = dn_cnt[d][l];
    end
    dc0 = done_cnt[d]; v0 = viol[d]; busy_bad = 0; got = 0; n = 0;
    @(negedge clk); start[d] = 1'b1;
    while (n < 4000) begin
      @(negedge clk); n++;
      if (n == 1) begin
        start[d] = 1'b0;
        n_checks++;
        if (load[d] !== 2'b01) $display("FAIL %s first_load got %b exp 01", name, load[d]);
        else n_pass++;
      end
      if (poke && n == 30) start[d] = 1'b1;
      if (poke && n == 31) start[d] = 1'b0;
      if (done[d] === 1'b1) begin got = 1; break; end
      if (busy[d] !== 1'b1) busy_bad++;
    end
    start[d] = 1'b0;
    n_checks++;
    if (!got) $display("FAIL %s done_timeout got none exp within 4000", name); else n_pass++;
    n_checks++;
    if (n != ec) $display("FAIL %s done_cycle got %0d exp %0d", name, n, ec); else n_pass++;
    n_checks++;
    if (busy_bad != 0 || busy[d] !== 1'b0)
      $display("FAIL %s busy_window got bad=%0d at_done=%b exp 0/0", name, busy_bad, busy[d]);
    else n_pass++;
    for (int l = 0; l < 2; l++) begin
      n_checks++;
      if (pass[d][l] !== 1'(ep[l]))
        $display("FAIL %s pass_l%0d got %b exp %0d", name, l, pass[d][l], ep[l]);
      else n_pass++;
      n_checks++;
      if (ltap[d][l*8 +: 8] !== 8'(et[l]))
        $display("FAIL %s tap_l%0d got %0d exp %0d", name, l, ltap[d][l*8 +: 8], et[l]);
      else n_pass++;
      n_checks++;
      if (up_cnt[d][l] - u0[l] != eu[l] || dn_cnt[d][l] - d0[l] != ed[l])
        $display("FAIL %s moves_l%0d got up=%0d dn=%0d exp up=%0d dn=%0d", name, l,
                 up_cnt[d][l] - u0[l], dn_cnt[d][l] - d0[l], eu[l], ed[l]);
      else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt[d] - dc0 != 1 || busy[d] !== 1'b0)
      $display("FAIL %s single_done got dones=%0d busy=%b exp 1/0", name, done_cnt[d] - dc0, busy[d]);
    else n_pass++;
    n_checks++;
    if (viol[d] != v0) $display("FAIL %s lane_exclusive got %0d exp 0", name, viol[d] - v0);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({busy[d], done[d], pass[d], ltap[d], load[d], move[d], dir[d], clr[d]} !== '0)
        $display("FAIL %s zero_d%0d got busy=%b done=%b pass=%b tap=%h ctl=%b%b%b%b exp all 0",
                 name, d, busy[d], done[d], pass[d], ltap[d], load[d], move[d], dir[d], clr[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    set_edge(0, 0, 10);
    set_edge(0, 1, 5);
    run_train(0, "basic", 1'b0);
  endtask

  task automatic test_max_taps();
    for (int t = 0; t < 32; t++) pat[0][0][t] = 2'b10;
    oor_tap[0][0] = -1;
    set_edge(0, 1, 7);
    run_train(0, "max_taps", 1'b0);
  endtask

  task automatic test_out_of_range();
    set_edge(0, 0, 12);
    oor_tap[0][0] = 7;
    set_edge(0, 1, 3);
    run_train(0, "out_of_range", 1'b0);
  endtask

  task automatic test_backoff();
    set_edge(1, 0, 2);
    set_edge(1, 1, 12);
    run_train(1, "backoff", 1'b0);
  endtask

  task automatic test_x_samples();
    for (int t = 0; t < 32; t++) begin
      if (t <= 4) pat[0][0][t] = 2'b10;
      else if (t == 5) pat[0][0][t] = 2'b11;
      else if (t <= 8) pat[0][0][t] = 2'b01;
      else if (t == 9) pat[0][0][t] = 2'b10;
      else pat[0][0][t] = 2'b01;
    end
    oor_tap[0][0] = -1;
    set_edge(0, 1, 6);
    pat[0][1][3] = 2'b00;
    run_train(0, "x_samples", 1'b0);
  endtask

  task automatic test_random();
    int k, r;
    for (int it = 0; it < 6; it++) begin
      for (int l = 0; l < 2; l++) begin
        k = $urandom_range(1, 31);
        for (int t = 0; t < 32; t++) begin
          r = $urandom_range(0, 9);
          if (r == 0) pat[it % 2][l][t] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
          else pat[it % 2][l][t] = (t < k) ? 2'b10 : 2'b01;
        end
        oor_tap[it % 2][l] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : -1;
      end
      run_train(it % 2, $sformatf("random%0d", it), 1'b0);
    end
  endtask

  task automatic test_reset_midrun();
    set_edge(0, 0, 10);
    set_edge(0, 1, 5);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midrun");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_train(0, "rerun_with_busy_start", 1'b1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      done_cnt[d] = 0;
      viol[d] = 0;
      for (int l = 0; l < 2; l++) begin
        set_edge(d, l, 4);
        up_cnt[d][l] = 0;
        dn_cnt[d][l] = 0;
      end
    end
    test_reset();
    test_basic();
    test_max_taps();
    test_out_of_range();
    test_backoff();
    test_x_samples();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
